// File: rtl/template_ram_writer.sv
// ---------------------------------------------------------------------------
// template_ram_writer
//
// Loads a block of words from a valid/ready stream into a RAM write port.
// A load is started with a base address and word count. The k-th accepted
// word (k from 0) is written to (base_addr + k) mod 2^ADDR_WIDTH, one cycle
// after the edge that accepted it.
//
// Build option:
//   TEMPLATE_CHECKSUM_EN  - when defined, checksum is the running modulo
//                           2^DATA_WIDTH sum of the words accepted in the
//                           current/last load; otherwise checksum is tied to 0.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - single-cycle load request (ignored while busy)
//   abort      - cancels an active load (ignored outside LOAD)
//   base_addr  - first RAM address, sampled on an accepted start
//   length     - word count 1..2^ADDR_WIDTH, sampled on an accepted start
//   s_data     - stream word
//   s_valid    - stream word present
//   s_ready    - writer accepts a word this cycle (high exactly in LOAD)
//   wr_en      - RAM write strobe
//   wr_addr    - RAM write address
//   wr_data    - RAM write data
//   busy       - high in LOAD and DONE
//   done       - one-cycle pulse with the final write
//   err        - one-cycle pulse after a start with an illegal length
//   word_cnt   - words accepted in the current/last load
//   checksum   - running sum of accepted words (see build option)
// ---------------------------------------------------------------------------
module template_ram_writer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_cnt,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Largest legal length: exactly one full pass over the address space.
    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  len_ok;
    logic                  start_ok;
    logic                  accept;
    logic                  last_word;

    assign len_ok    = (length != '0) && (length <= LEN_MAX);
    assign start_ok  = (state == ST_IDLE) && start && len_ok;
    // Abort wins over a simultaneous accept: the offered word is dropped.
    assign accept    = (state == ST_LOAD) && s_valid && !abort;
    assign cnt_inc   = word_cnt + (ADDR_WIDTH + 1)'(1);
    assign last_word = accept && (cnt_inc == len_q);

    // Handshake and status are pure decodes of the state register so that
    // s_ready never depends on s_valid.
    assign s_ready = (state == ST_LOAD);
    assign busy    = (state == ST_LOAD) || (state == ST_DONE);
    // DONE is entered on the edge that accepts the final word, which is the
    // same edge that registers the final write, so done lines up with it.
    assign done    = (state == ST_DONE);

    // NOTE: reset is tested inside the clocked block, so it only acts on a
    // rising edge; every register is cleared there, including the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_ptr <= '0;
            len_q    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            word_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side sees the pre-edge value regardless of statement order.
            wr_en <= accept;
            err   <= (state == ST_IDLE) && start && !len_ok;

            if (accept) begin
                wr_addr  <= addr_ptr;
                wr_data  <= s_data;
                addr_ptr <= addr_ptr + ADDR_WIDTH'(1); // wraps modulo 2^ADDR_WIDTH
                word_cnt <= cnt_inc;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_LOAD;
                        addr_ptr <= base_addr;
                        len_q    <= length;
                        word_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_word) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TEMPLATE_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    // start_ok (IDLE) and accept (LOAD) can never be true together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + s_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_template_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_template_ram_writer
//
// Self-checking bench for template_ram_writer (ADDR_WIDTH=11, DATA_WIDTH=8).
// A table of directed loads with hand-derived results, a mid-load reset
// sequence, and randomized loads. Every load is followed cycle by cycle
// against an address/count/sum model computed from the load's rules.
// Honours TEMPLATE_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_template_ram_writer;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;
    logic [DW-1:0] checksum;

    int checks = 0;
    int errors = 0;

    template_ram_writer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .length   (length),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            valid_pct;   // -1: s_valid alternates 1,0,1,0,...
        int            abort_at;    // abort when offering word k; -1: never
        bit            exp_err;
        int            exp_wr;
        bit            exp_done;
        logic [AW-1:0] exp_last;
        logic [AW:0]   exp_cnt;
        logic [DW-1:0] exp_sum;     // value with the checksum feature built in
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sum_exp(input logic [DW-1:0] s);
`ifdef TEMPLATE_CHECKSUM_EN
        return s;
`else
        return '0;
`endif
    endfunction

    // One rising edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    // Runs one load request and follows it to completion, abort or rejection.
    task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int valid_pct, input bit ramp, input int abort_at,
                            input bit noise, output int n_wr, output bit saw_done,
                            output bit saw_err, output logic [AW-1:0] last_addr);
        int            li;
        int            k;
        int            m_sum;
        int            budget;
        bit            acc;
        bit            ab;
        logic [DW-1:0] d;

        li        = int'(len);
        n_wr      = 0;
        saw_done  = 1'b0;
        saw_err   = 1'b0;
        last_addr = '0;
        m_sum     = 0;

        start     = 1'b1;
        base_addr = base;
        length    = len;
        // abort and s_valid have no effect in IDLE
        abort     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data    = DW'($urandom);
        tick();
        idle_inputs();

        if (li < 1 || li > DEPTH) begin
            saw_err = err;
            check("rej_busy", 32'(busy), 0);
            check("rej_wr_en", 32'(wr_en), 0);
            check("rej_ready", 32'(s_ready), 0);
            tick();
            check("rej_err_one_cycle", 32'(err), 0);
            check("rej_still_idle", 32'(busy), 0);
            return;
        end

        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(s_ready), 1);
        check("start_err", 32'(err), 0);
        check("start_wr_en", 32'(wr_en), 0);
        check("start_cnt", 32'(word_cnt), 0);
        check("start_sum", 32'(checksum), 0);

        k      = 0;
        budget = 20 * li + 50;
        for (int i = 0; ; i++) begin
            if (budget == 0) begin
                check("load_timeout", 32'(k), 32'(li));
                idle_inputs();
                return;
            end
            budget--;

            if (valid_pct < 0) s_valid = (i % 2 == 0);
            else               s_valid = ($urandom_range(0, 99) < valid_pct);
            d      = ramp ? DW'((k + 1) * 17) : DW'($urandom);
            s_data = d;
            ab     = (abort_at == k) && s_valid;
            abort  = ab;
            acc    = s_valid && !ab;
            if (noise && $urandom_range(0, 3) == 0) begin
                // start while busy must be ignored, including illegal lengths
                start     = 1'b1;
                base_addr = AW'($urandom);
                length    = (AW + 1)'($urandom_range(0, 2 * DEPTH - 1));
            end
            tick();
            idle_inputs();

            if (ab) begin
                check("abort_wr_en", 32'(wr_en), 0);
                check("abort_done", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
                check("abort_ready", 32'(s_ready), 0);
                check("abort_cnt", 32'(word_cnt), 32'(k));
                tick();
                check("abort_quiet_wr", 32'(wr_en), 0);
                check("abort_quiet_done", 32'(done), 0);
                return;
            end

            check("wr_en", 32'(wr_en), 32'(acc));
            check("busy_err", 32'(err), 0);
            if (acc) begin
                check("wr_addr", 32'(wr_addr), 32'((int'(base) + k) % DEPTH));
                check("wr_data", 32'(wr_data), 32'(d));
                last_addr = wr_addr;
                k++;
                n_wr++;
                m_sum += int'(d);
                check("word_cnt", 32'(word_cnt), 32'(k));
                check("checksum", 32'(checksum), 32'(sum_exp(DW'(m_sum))));
                if (k == li) begin
                    saw_done = done;
                    check("done_with_last_wr", 32'(done), 1);
                    check("done_busy", 32'(busy), 1);
                    check("done_ready", 32'(s_ready), 0);
                    if (noise) begin
                        start   = 1'b1;
                        length  = '0;
                        s_valid = 1'b1;
                    end
                    tick();
                    idle_inputs();
                    check("post_done", 32'(done), 0);
                    check("post_busy", 32'(busy), 0);
                    check("post_wr_en", 32'(wr_en), 0);
                    check("post_err", 32'(err), 0);
                    check("post_cnt_hold", 32'(word_cnt), 32'(li));
                    check("post_sum_hold", 32'(checksum), 32'(sum_exp(DW'(m_sum))));
                    return;
                end
            end
            check("early_done", 32'(done), 0);
            check("load_busy", 32'(busy), 1);
            check("load_ready", 32'(s_ready), 1);
        end
    endtask

    initial begin
        int            n_wr;
        bit            saw_done;
        bit            saw_err;
        logic [AW-1:0] last_addr;

        //            base     len      vpct abort err wr done last    cnt      sum
        vecs[0] = '{11'h010, 12'd4,    100, -1,  0,  4,  1, 11'h013, 12'd4,    8'hAA};
        vecs[1] = '{11'h7FE, 12'd4,    100, -1,  0,  4,  1, 11'h001, 12'd4,    8'hAA};
        vecs[2] = '{11'h123, 12'd0,    100, -1,  1,  0,  0, 11'h000, 12'd4,    8'hAA};
        vecs[3] = '{11'h123, 12'd2049, 100, -1,  1,  0,  0, 11'h000, 12'd4,    8'hAA};
        vecs[4] = '{11'h100, 12'd3,    -1,  -1,  0,  3,  1, 11'h102, 12'd3,    8'h66};
        vecs[5] = '{11'h200, 12'd5,    100,  2,  0,  2,  0, 11'h201, 12'd2,    8'h33};
        vecs[6] = '{11'h400, 12'd2048, 100, -1,  0,  2048, 1, 11'h3FF, 12'd2048, 8'h00};
        vecs[7] = '{11'h7FF, 12'd1,    100, -1,  0,  1,  1, 11'h7FF, 12'd1,    8'h11};

        idle_inputs();
        base_addr = '0;
        length    = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(s_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_cnt", 32'(word_cnt), 0);
        check("rst_sum", 32'(checksum), 0);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int v = 0; v < 8; v++) begin
            run_load(vecs[v].base, vecs[v].len, vecs[v].valid_pct, 1'b1, vecs[v].abort_at,
                     1'b0, n_wr, saw_done, saw_err, last_addr);
            check($sformatf("vec%0d_err", v), 32'(saw_err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_writes", v), 32'(n_wr), 32'(vecs[v].exp_wr));
            check($sformatf("vec%0d_done", v), 32'(saw_done), 32'(vecs[v].exp_done));
            if (vecs[v].exp_wr > 0)
                check($sformatf("vec%0d_last_addr", v), 32'(last_addr), 32'(vecs[v].exp_last));
            check($sformatf("vec%0d_cnt", v), 32'(word_cnt), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_sum", v), 32'(checksum), 32'(sum_exp(vecs[v].exp_sum)));
            tick();
        end

        // Reset for one cycle in the middle of a load
        start     = 1'b1;
        base_addr = 11'h050;
        length    = 12'd5;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        tick();
        check("mid_pre_cnt", 32'(word_cnt), 2);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", 32'(s_ready), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_wr_addr", 32'(wr_addr), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_cnt", 32'(word_cnt), 0);
        check("mid_rst_sum", 32'(checksum), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_rst_wr_en", 32'(wr_en), 0);
            check("after_rst_done", 32'(done), 0);
            check("after_rst_busy", 32'(busy), 0);
        end
        idle_inputs();

        // Randomized loads with noise on start/abort/s_valid
        for (int r = 0; r < 40; r++) begin
            logic [AW:0] len;
            int          ab_at;
            int          li;
            if ($urandom_range(0, 5) == 0)
                len = ($urandom_range(0, 1) == 0) ? '0
                                                  : (AW + 1)'($urandom_range(DEPTH + 1, 2 * DEPTH - 1));
            else
                len = (AW + 1)'($urandom_range(1, 40));
            li    = int'(len);
            ab_at = ($urandom_range(0, 4) == 0 && li >= 1 && li <= DEPTH)
                    ? int'($urandom_range(0, li - 1)) : -1;
            run_load(AW'($urandom), len, int'($urandom_range(30, 100)), 1'b0, ab_at,
                     1'b1, n_wr, saw_done, saw_err, last_addr);
            if (li < 1 || li > DEPTH) begin
                check("rnd_err", 32'(saw_err), 1);
                check("rnd_rej_writes", 32'(n_wr), 0);
            end else if (ab_at >= 0) begin
                check("rnd_abort_writes", 32'(n_wr), 32'(ab_at));
                check("rnd_abort_done", 32'(saw_done), 0);
            end else begin
                check("rnd_writes", 32'(n_wr), 32'(li));
                check("rnd_done", 32'(saw_done), 1);
            end
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/template_ram_writer.md
TEMPLATE_RAM_WRITER -- requirements
Module: template_ram_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, RAM address width (2048 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word and stream byte width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port abort  input  1  cancels an active load.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first RAM address; sampled on accepted start.
REQ-008 SHALL have port length  input  ADDR_WIDTH+1  word count, legal 1..2^ADDR_WIDTH; sampled on accepted start.
REQ-009 SHALL have port s_data  input  DATA_WIDTH  stream word.
REQ-010 SHALL have port s_valid  input  1  stream word present.
REQ-011 SHALL have port s_ready  output  1  writer accepts a word this cycle.
REQ-012 SHALL have port wr_en  output  1  RAM write strobe.
REQ-013 SHALL have port wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-014 SHALL have port wr_data  output  DATA_WIDTH  RAM write data.
REQ-015 SHALL have port busy  output  1  high in LOAD and DONE states.
REQ-016 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have port err  output  1  one-cycle pulse on rejected start.
REQ-018 SHALL have port word_cnt  output  ADDR_WIDTH+1  words accepted in current/last load.
REQ-019 SHALL have port checksum  output  DATA_WIDTH  running sum of accepted words.

Function
REQ-020 SHALL implement states IDLE, LOAD, DONE; IDLE->LOAD on start with 1<=length<=2^ADDR_WIDTH; LOAD->DONE on edge accepting final word; DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL, on start with length 0 or length >2^ADDR_WIDTH, pulse err the next cycle and remain IDLE.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL drive s_ready=1 exactly when state is LOAD (combinational on state only, not on s_valid).
REQ-024 SHALL accept a word on each edge where s_valid & s_ready; no accept otherwise; back-to-back accepts each cycle.
REQ-025 SHALL register each accepted word: wr_en=1, wr_addr, wr_data valid the cycle after the accepting edge (latency 1); wr_en=0 otherwise.
REQ-026 SHALL write the k-th accepted word (k from 0) to (base_addr + k) mod 2^ADDR_WIDTH; address wraps from 2^ADDR_WIDTH-1 to 0.
REQ-027 SHALL clear word_cnt to 0 on accepted start and increment by 1 per accepted word; hold value after completion until next accepted start.
REQ-028 SHALL assert done in the DONE cycle, coincident with the final wr_en.
REQ-029 SHALL, on abort in LOAD, return to IDLE next edge, no done; a word accepted on the abort edge is discarded (no wr_en); abort has priority over accept.
REQ-030 SHALL ignore abort outside LOAD.

Reset
REQ-031 SHALL, while rst_n=0 at a rising edge, set state IDLE and s_ready, wr_en, busy, done, err to 0; wr_addr, wr_data, word_cnt, checksum to 0.
REQ-032 SHALL treat reset mid-LOAD identically to REQ-031; no done, no further wr_en.

Configuration
REQ-033 SHALL, with macro TEMPLATE_CHECKSUM_EN defined, clear checksum on accepted start and add each accepted s_data modulo 2^DATA_WIDTH on its accepting edge.
REQ-034 SHALL, without TEMPLATE_CHECKSUM_EN, keep the checksum port and tie it to 0, with no adder logic.

Verification
REQ-035 SHALL cover: base_addr=0x010, length=4, s_valid held high, data 0x11,0x22,0x33,0x44 -> wr_en 4 consecutive cycles at 0x010..0x013, done with last write, word_cnt=4, checksum=0xAA (macro on).
REQ-036 SHALL cover: base_addr=0x7FE, length=4 -> writes at 0x7FE,0x7FF,0x000,0x001.
REQ-037 SHALL cover: length=0 and length=2049 -> err pulse, busy stays 0, no wr_en.
REQ-038 SHALL cover: length=3, s_valid toggling 1,0,1,0,1 -> exactly 3 writes, each one cycle after its accept, done on third.
REQ-039 SHALL cover: abort asserted with s_valid after 2 of 5 words -> 2 writes only, no done, IDLE next cycle, new start accepted.
REQ-040 SHALL cover: rst_n=0 for one cycle during LOAD -> all outputs zero next cycle, no done; macro off -> checksum always 0.
